// File: rtl/mac_rx_pkg.sv
// rtl/mac_rx_pkg.sv - entry field layout and write-FSM encoding for the MAC receive packet FIFO
package mac_rx_pkg;

    // Write-side state: ACCEPT stores beats, DROP discards the rest of a frame that overflowed.
    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } wr_state_t;

    // Entry layout is {tlast, tdata, tkeep} with tkeep in the low bits.
    localparam int TKEEP_LSB = 0;

    function automatic int tdata_lsb(input int keep_width);
        return keep_width;
    endfunction

    function automatic int tlast_bit(input int data_width, input int keep_width);
        return data_width + keep_width;
    endfunction

endpackage

// File: rtl/mac_rx_fifo_ram.sv
// rtl/mac_rx_fifo_ram.sv - simple dual-port storage, synchronous write, asynchronous read
module mac_rx_fifo_ram #(
    parameter int WIDTH      = 10,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Storage is not reset; only the pointers decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_rx_packet_fifo.sv
// rtl/mac_rx_packet_fifo.sv - MAC receive FIFO with store-and-forward frame drop or cut-through
module mac_rx_packet_fifo
    import mac_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int PACKET_MODE = 1,
    parameter int ENTRY_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  rx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]  rx_axis_tkeep,
    input  logic                   rx_axis_tvalid,
    input  logic                   rx_axis_tlast,
    input  logic                   rx_axis_tuser,
    output logic                   rx_axis_tready,
    output logic [ENTRY_WIDTH-1:0] RX_FIFO_pipe_read_data,
    input  logic                   RX_FIFO_pipe_read_req,
    output logic                   RX_FIFO_pipe_read_ack,
    output logic [15:0]            frame_count,
    output logic [15:0]            drop_count,
    output logic [ADDR_WIDTH:0]    level
);

    localparam int TDATA_LSB = tdata_lsb(KEEP_WIDTH);
    localparam int TLAST_BIT = tlast_bit(DATA_WIDTH, KEEP_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_PTR = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0]  wr_ptr;
    logic [ADDR_WIDTH:0]  commit_ptr;
    logic [ADDR_WIDTH:0]  rd_ptr;
    logic [ADDR_WIDTH:0]  used;
    wr_state_t            state;
    logic                 full;
    logic                 empty;
    logic                 beat_ok;
    logic                 pop;
    logic                 wr_en;
    logic [15:0]          drop_next;
    logic [ENTRY_WIDTH-1:0] wr_entry;
    logic [ENTRY_WIDTH-1:0] rd_entry;

    // Full counts uncommitted beats too; level and empty only see committed frames.
    assign used  = wr_ptr - rd_ptr;
    assign full  = (used == DEPTH_PTR);
    assign empty = (commit_ptr == rd_ptr);
    assign level = commit_ptr - rd_ptr;

    // Mid-frame tready stays high so an overflowing frame is swallowed rather than stalled.
    assign rx_axis_tready = (PACKET_MODE == 0) ? !full :
                            (state == ST_DROP) ? 1'b1 :
                            (wr_ptr == commit_ptr) ? !full : 1'b1;

    assign beat_ok = rx_axis_tvalid && rx_axis_tready;
    assign wr_en   = beat_ok && !full && ((PACKET_MODE == 0) || (state == ST_ACCEPT));
    assign pop     = RX_FIFO_pipe_read_req && !empty;

    assign drop_next = (drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1;

    assign RX_FIFO_pipe_read_ack  = !empty;
    assign RX_FIFO_pipe_read_data = empty ? '0 : rd_entry;

    // Pack the incoming beat into the stored entry layout.
    always_comb begin
        wr_entry = '0;
        wr_entry[TLAST_BIT] = rx_axis_tlast;
        wr_entry[TDATA_LSB +: DATA_WIDTH] = rx_axis_tdata;
        wr_entry[TKEEP_LSB +: KEEP_WIDTH] = rx_axis_tkeep;
    end

    // Pointer, counter and write-FSM update; reads and writes proceed independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            rd_ptr      <= '0;
            state       <= ST_ACCEPT;
            frame_count <= 16'd0;
            drop_count  <= 16'd0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (PACKET_MODE == 0) begin
                if (beat_ok) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    commit_ptr <= wr_ptr + 1'b1;
                    if (rx_axis_tlast) begin
                        frame_count <= frame_count + 16'd1;
                    end
                end
            end else begin
                case (state)
                    ST_ACCEPT: begin
                        if (beat_ok) begin
                            if (!full) begin
                                if (rx_axis_tlast && rx_axis_tuser) begin
                                    wr_ptr     <= commit_ptr;
                                    drop_count <= drop_next;
                                end else begin
                                    wr_ptr <= wr_ptr + 1'b1;
                                    if (rx_axis_tlast) begin
                                        commit_ptr  <= wr_ptr + 1'b1;
                                        frame_count <= frame_count + 16'd1;
                                    end
                                end
                            end else begin
                                wr_ptr <= commit_ptr;
                                if (rx_axis_tlast) begin
                                    drop_count <= drop_next;
                                end else begin
                                    state <= ST_DROP;
                                end
                            end
                        end
                    end
                    ST_DROP: begin
                        if (beat_ok && rx_axis_tlast) begin
                            state      <= ST_ACCEPT;
                            drop_count <= drop_next;
                        end
                    end
                    default: state <= ST_ACCEPT;
                endcase
            end
        end
    end

    mac_rx_fifo_ram #(
        .WIDTH      (ENTRY_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_entry)
    );

endmodule

// File: tb/tb_mac_rx_packet_fifo.sv
// tb/tb_mac_rx_packet_fifo.sv - scoreboard bench for packet mode (depth 16) and cut-through (depth 4)
module tb_mac_rx_packet_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [7:0]  a_tdata;
    logic [0:0]  a_tkeep;
    logic        a_tvalid, a_tlast, a_tuser, a_tready, a_req, a_ack;
    logic [9:0]  a_rdata;
    logic [15:0] a_fc, a_dc;
    logic [4:0]  a_level;

    logic [7:0]  b_tdata;
    logic [0:0]  b_tkeep;
    logic        b_tvalid, b_tlast, b_tuser, b_tready, b_req, b_ack;
    logic [9:0]  b_rdata;
    logic [15:0] b_fc, b_dc;
    logic [2:0]  b_level;

    int total = 0;
    int bad   = 0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    mac_rx_packet_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .PACKET_MODE(1)) dut_a (
        .clk(clk), .reset(reset),
        .rx_axis_tdata(a_tdata), .rx_axis_tkeep(a_tkeep), .rx_axis_tvalid(a_tvalid),
        .rx_axis_tlast(a_tlast), .rx_axis_tuser(a_tuser), .rx_axis_tready(a_tready),
        .RX_FIFO_pipe_read_data(a_rdata), .RX_FIFO_pipe_read_req(a_req),
        .RX_FIFO_pipe_read_ack(a_ack), .frame_count(a_fc), .drop_count(a_dc), .level(a_level)
    );

    mac_rx_packet_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .PACKET_MODE(0)) dut_b (
        .clk(clk), .reset(reset),
        .rx_axis_tdata(b_tdata), .rx_axis_tkeep(b_tkeep), .rx_axis_tvalid(b_tvalid),
        .rx_axis_tlast(b_tlast), .rx_axis_tuser(b_tuser), .rx_axis_tready(b_tready),
        .RX_FIFO_pipe_read_data(b_rdata), .RX_FIFO_pipe_read_req(b_req),
        .RX_FIFO_pipe_read_ack(b_ack), .frame_count(b_fc), .drop_count(b_dc), .level(b_level)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0;
    endtask

    task automatic idle_b();
        b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0;
    endtask

    // Presents one beat and returns just after the edge that accepted it, tvalid still high.
    task automatic send_a(input logic [7:0] d, input logic last, input logic user);
        int n = 0;
        a_tdata = d; a_tkeep = 1'b1; a_tlast = last; a_tuser = user; a_tvalid = 1'b1;
        while (!a_tready && n < 200) begin step(); n++; end
        total++;
        if (a_tready !== 1'b1) begin bad++; $display("FAIL send_a_timeout tready=%b want=1", a_tready); end
        step();
    endtask

    task automatic send_b(input logic [7:0] d, input logic last);
        int n = 0;
        b_tdata = d; b_tkeep = 1'b1; b_tlast = last; b_tuser = 1'b1; b_tvalid = 1'b1;
        while (!b_tready && n < 200) begin step(); n++; end
        total++;
        if (b_tready !== 1'b1) begin bad++; $display("FAIL send_b_timeout tready=%b want=1", b_tready); end
        step();
    endtask

    task automatic do_reset();
        idle_a(); idle_b(); a_req = 1'b0; b_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (a_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%b want=1", a_tready); end
        total++; if (a_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", a_ack); end
        total++; if (a_rdata !== 10'd0) begin bad++; $display("FAIL reset_data got=%h want=0", a_rdata); end
        total++; if (a_level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", a_level); end
        total++; if (a_fc !== 16'd0 || a_dc !== 16'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d want=0/0", a_fc, a_dc); end
        total++; if (b_tready !== 1'b1 || b_ack !== 1'b0 || b_level !== 3'd0) begin bad++; $display("FAIL reset_b got=%b%b%0d want=1 0 0", b_tready, b_ack, b_level); end
    endtask

    task automatic test_good_frame();
        int n;
        logic [9:0] exp;
        do_reset(); qa.delete();
        qa.push_back({1'b0, 8'hA1, 1'b1}); send_a(8'hA1, 1'b0, 1'b0);
        qa.push_back({1'b0, 8'hA2, 1'b1}); send_a(8'hA2, 1'b0, 1'b0);
        qa.push_back({1'b1, 8'hA3, 1'b1}); send_a(8'hA3, 1'b1, 1'b0);
        idle_a();
        total++; if (a_level !== 5'd3) begin bad++; $display("FAIL good_level got=%0d want=3", a_level); end
        total++; if (a_fc !== 16'd1) begin bad++; $display("FAIL good_frame_count got=%0d want=1", a_fc); end
        a_req = 1'b1; n = 0;
        while (qa.size() > 0 && n < 100) begin
            if (a_ack) begin
                exp = qa.pop_front(); total++;
                if (a_rdata !== exp) begin bad++; $display("FAIL good_data got=%h want=%h", a_rdata, exp); end
            end
            step(); n++;
        end
        a_req = 1'b0;
        total++; if (qa.size() != 0 || a_ack !== 1'b0) begin bad++; $display("FAIL good_drain left=%0d ack=%b want=0 0", qa.size(), a_ack); end
    endtask

    task automatic test_bad_frame();
        int n;
        logic [9:0] exp;
        do_reset(); qa.delete();
        for (int i = 0; i < 4; i++) begin
            send_a(8'h10 + 8'(i), i == 3, i == 3);
            total++;
            if (a_ack !== 1'b0 || a_level !== 5'd0) begin bad++; $display("FAIL bad_visible ack=%b level=%0d want=0 0", a_ack, a_level); end
        end
        idle_a();
        total++; if (a_dc !== 16'd1 || a_fc !== 16'd0) begin bad++; $display("FAIL bad_counts drop=%0d frames=%0d want=1 0", a_dc, a_fc); end
        qa.push_back({1'b0, 8'hB1, 1'b1}); send_a(8'hB1, 1'b0, 1'b0);
        qa.push_back({1'b1, 8'hB2, 1'b1}); send_a(8'hB2, 1'b1, 1'b0);
        idle_a();
        total++; if (a_level !== 5'd2 || a_fc !== 16'd1) begin bad++; $display("FAIL bad_next_frame level=%0d frames=%0d want=2 1", a_level, a_fc); end
        a_req = 1'b1; n = 0;
        while (qa.size() > 0 && n < 100) begin
            if (a_ack) begin
                exp = qa.pop_front(); total++;
                if (a_rdata !== exp) begin bad++; $display("FAIL bad_next_data got=%h want=%h", a_rdata, exp); end
            end
            step(); n++;
        end
        a_req = 1'b0;
        total++; if (qa.size() != 0) begin bad++; $display("FAIL bad_drain left=%0d want=0", qa.size()); end
    endtask

    task automatic test_oversize();
        int n;
        logic [9:0] exp;
        do_reset(); qa.delete();
        for (int i = 0; i < 20; i++) begin
            total++;
            if (a_tready !== 1'b1) begin bad++; $display("FAIL over_tready beat=%0d got=%b want=1", i, a_tready); end
            send_a(8'(i), i == 19, 1'b0);
        end
        idle_a();
        total++; if (a_dc !== 16'd1) begin bad++; $display("FAIL over_drop got=%0d want=1", a_dc); end
        total++; if (a_level !== 5'd0 || a_ack !== 1'b0) begin bad++; $display("FAIL over_level got=%0d ack=%b want=0 0", a_level, a_ack); end
        qa.push_back({1'b0, 8'hE1, 1'b1}); send_a(8'hE1, 1'b0, 1'b0);
        qa.push_back({1'b1, 8'hE2, 1'b1}); send_a(8'hE2, 1'b1, 1'b0);
        idle_a();
        total++; if (a_level !== 5'd2) begin bad++; $display("FAIL over_next_level got=%0d want=2", a_level); end
        a_req = 1'b1; n = 0;
        while (qa.size() > 0 && n < 100) begin
            if (a_ack) begin
                exp = qa.pop_front(); total++;
                if (a_rdata !== exp) begin bad++; $display("FAIL over_next_data got=%h want=%h", a_rdata, exp); end
            end
            step(); n++;
        end
        a_req = 1'b0;
        total++; if (qa.size() != 0) begin bad++; $display("FAIL over_drain left=%0d want=0", qa.size()); end
    endtask

    task automatic test_cut_through();
        int n;
        logic [9:0] exp;
        do_reset(); qb.delete();
        for (int i = 0; i < 4; i++) begin
            qb.push_back({1'b0, 8'h50 + 8'(i), 1'b1});
            send_b(8'h50 + 8'(i), 1'b0);
        end
        b_tdata = 8'h54; b_tlast = 1'b1; b_tvalid = 1'b1;
        total++; if (b_tready !== 1'b0 || b_level !== 3'd4) begin bad++; $display("FAIL ct_full tready=%b level=%0d want=0 4", b_tready, b_level); end
        step();
        total++; if (b_tready !== 1'b0 || b_level !== 3'd4) begin bad++; $display("FAIL ct_hold tready=%b level=%0d want=0 4", b_tready, b_level); end
        b_req = 1'b1;
        exp = qb.pop_front(); total++;
        if (b_ack !== 1'b1 || b_rdata !== exp) begin bad++; $display("FAIL ct_head ack=%b data=%h want=1 %h", b_ack, b_rdata, exp); end
        step();
        b_req = 1'b0;
        total++; if (b_tready !== 1'b1) begin bad++; $display("FAIL ct_tready_after_pop got=%b want=1", b_tready); end
        qb.push_back({1'b1, 8'h54, 1'b1});
        step();
        idle_b();
        total++; if (b_level !== 3'd4 || b_fc !== 16'd1 || b_dc !== 16'd0) begin bad++; $display("FAIL ct_after level=%0d frames=%0d drops=%0d want=4 1 0", b_level, b_fc, b_dc); end
        b_req = 1'b1; n = 0;
        while (qb.size() > 0 && n < 100) begin
            if (b_ack) begin
                exp = qb.pop_front(); total++;
                if (b_rdata !== exp) begin bad++; $display("FAIL ct_data got=%h want=%h", b_rdata, exp); end
            end
            step(); n++;
        end
        b_req = 1'b0;
        total++; if (qb.size() != 0 || b_level !== 3'd0) begin bad++; $display("FAIL ct_drain left=%0d level=%0d want=0 0", qb.size(), b_level); end
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        int first = -1;
        int last = -1;
        do_reset(); qa.delete();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    qa.push_back({1'b1, 8'(i * 3 + 1), 1'b1});
                    send_a(8'(i * 3 + 1), 1'b1, 1'b0);
                end
                idle_a();
            end
            begin
                logic [9:0] exp;
                int n = 0;
                a_req = 1'b1;
                while (pops < 40 && n < 400) begin
                    if (a_ack) begin
                        exp = qa.pop_front(); total++;
                        if (a_rdata !== exp) begin bad++; $display("FAIL b2b_data got=%h want=%h", a_rdata, exp); end
                        if (first < 0) first = n;
                        last = n; pops++;
                    end
                    step(); n++;
                end
                a_req = 1'b0;
            end
        join
        total++; if (pops != 40) begin bad++; $display("FAIL b2b_pops got=%0d want=40", pops); end
        total++; if (last - first != 39) begin bad++; $display("FAIL b2b_rate span=%0d want=39", last - first); end
        total++; if (a_fc !== 16'd40 || a_level !== 5'd0) begin bad++; $display("FAIL b2b_counts frames=%0d level=%0d want=40 0", a_fc, a_level); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        logic [9:0] exp;
        do_reset(); qa.delete();
        send_a(8'hC0, 1'b1, 1'b0);
        send_a(8'hC1, 1'b0, 1'b0);
        send_a(8'hC2, 1'b0, 1'b0);
        do_reset();
        total++; if (a_level !== 5'd0 || a_ack !== 1'b0 || a_rdata !== 10'd0) begin bad++; $display("FAIL rmid_out level=%0d ack=%b data=%h want=0 0 0", a_level, a_ack, a_rdata); end
        total++; if (a_fc !== 16'd0 || a_dc !== 16'd0 || a_tready !== 1'b1) begin bad++; $display("FAIL rmid_state frames=%0d drops=%0d tready=%b want=0 0 1", a_fc, a_dc, a_tready); end
        for (int i = 0; i < 3; i++) begin
            qa.push_back({i == 2, 8'hD0 + 8'(i), 1'b1});
            send_a(8'hD0 + 8'(i), i == 2, 1'b0);
        end
        idle_a();
        a_req = 1'b1; n = 0;
        while (qa.size() > 0 && n < 100) begin
            if (a_ack) begin
                exp = qa.pop_front(); total++;
                if (a_rdata !== exp) begin bad++; $display("FAIL rmid_data got=%h want=%h", a_rdata, exp); end
            end
            step(); n++;
        end
        a_req = 1'b0;
        total++; if (qa.size() != 0 || a_fc !== 16'd1) begin bad++; $display("FAIL rmid_after left=%0d frames=%0d want=0 1", qa.size(), a_fc); end
    endtask

    initial begin
        reset = 1'b1;
        a_tdata = '0; a_tkeep = '0; a_req = 1'b0;
        b_tdata = '0; b_tkeep = '0; b_req = 1'b0;
        idle_a(); idle_b();
        step();
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_oversize();
        test_cut_through();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
